ext_stream_fifo: RTL

- MMIO peripheral on the SoC external interface window (0x8001_0000). It consumes the EXT_DIN/EXT_WEA/EXT_EN/EXT_ADDR strobes and drives EXT_DOUT.
- Bridges the core's load/store traffic to a pair of word-wide streaming FIFOs:
  - TX: CPU writes -> external valid/ready sink.
  - RX: external valid/ready source -> CPU reads.
- Sits directly downstream of the SoC top's PORT5 AHB slave bridge, which has zero pending cycles.

---
 rtl/ext_stream_fifo_if.sv | 48 ++++
 rtl/ext_stream_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ext_stream_fifo_if.sv
// ext_stream_fifo_if
//   Groups the MMIO strobes and both stream handshakes of ext_stream_fifo.
//   slave  : the FIFO peripheral (consumes MMIO strobes, drives read data,
//            sources the TX stream, sinks the RX stream).
//   master : the SoC bridge / stream endpoints side.
//   Signals:
//     mmio_din/mmio_wea/mmio_en/mmio_addr  MMIO access strobes
//     mmio_dout                            registered MMIO read data
//     tx_data/tx_valid/tx_ready            TX stream (peripheral -> sink)
//     rx_data/rx_valid/rx_ready            RX stream (source -> peripheral)
//     irq                                  only with EXT_STREAM_FIFO_IRQ_EN
interface ext_stream_fifo_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 16
);
    logic [DWIDTH-1:0] mmio_din;
    logic [3:0]        mmio_wea;
    logic              mmio_en;
    logic [AWIDTH-1:0] mmio_addr;
    logic [DWIDTH-1:0] mmio_dout;
    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DWIDTH-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
`ifdef EXT_STREAM_FIFO_IRQ_EN
    logic              irq;

    modport slave (
        input  mmio_din, mmio_wea, mmio_en, mmio_addr, tx_ready, rx_data, rx_valid,
        output mmio_dout, tx_data, tx_valid, rx_ready, irq
    );
    modport master (
        output mmio_din, mmio_wea, mmio_en, mmio_addr, tx_ready, rx_data, rx_valid,
        input  mmio_dout, tx_data, tx_valid, rx_ready, irq
    );
`else
    modport slave (
        input  mmio_din, mmio_wea, mmio_en, mmio_addr, tx_ready, rx_data, rx_valid,
        output mmio_dout, tx_data, tx_valid, rx_ready
    );
    modport master (
        output mmio_din, mmio_wea, mmio_en, mmio_addr, tx_ready, rx_data, rx_valid,
        input  mmio_dout, tx_data, tx_valid, rx_ready
    );
`endif
endinterface

// File: rtl/ext_stream_fifo.sv
// ext_stream_fifo
//   MMIO peripheral bridging CPU load/store traffic to two word-wide FIFOs:
//   TX (CPU writes -> valid/ready sink) and RX (valid/ready source -> CPU reads).
//   Register map (mmio_addr[3:2], aliases every 16 bytes):
//     0x0 TXDATA W push | 0x4 RXDATA R pop | 0x8 STATUS R | 0xC CTRL W
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  ext_stream_fifo_if.slave (MMIO strobes, read data, both streams)
//   Optional feature macro: EXT_STREAM_FIFO_IRQ_EN adds bus.irq and the
//   CTRL[7:4] interrupt mask {rx_underflow, tx_overflow, rx_nonempty, tx_empty}.
module ext_stream_fifo #(
    parameter int DWIDTH     = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int AWIDTH     = 16
) (
    input  logic             clk,
    input  logic             rst,
    ext_stream_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_RXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic [DWIDTH-1:0]     r_tx_mem [DEPTH];
    logic [DWIDTH-1:0]     r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [CW-1:0]         r_tx_cnt, r_rx_cnt;
    logic                  r_tx_of, r_rx_uf;
    logic [DWIDTH-1:0]     r_dout;

    logic              w_wr, w_rd, w_ctrl_wr;
    logic [1:0]        w_sel;
    logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic              w_tx_push_req, w_tx_push, w_tx_pop, w_tx_flush;
    logic              w_rx_pop_req, w_rx_pop, w_rx_push, w_rx_ready, w_rx_flush;
    logic              w_clr_sticky;
    logic [DWIDTH-1:0] w_status, w_rd_data;
    logic              w_unused_addr;

    assign w_wr      = bus.mmio_en & (|bus.mmio_wea);
    assign w_rd      = bus.mmio_en & ~(|bus.mmio_wea);
    assign w_sel     = bus.mmio_addr[3:2];
    assign w_ctrl_wr = w_wr & (w_sel == A_CTRL);
    assign w_unused_addr = ^{bus.mmio_addr[AWIDTH-1:4], bus.mmio_addr[1:0]};

    assign w_tx_full  = (r_tx_cnt == CNT_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CNT_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);

    assign w_tx_flush   = w_ctrl_wr & bus.mmio_din[0];
    assign w_rx_flush   = w_ctrl_wr & bus.mmio_din[1];
    assign w_clr_sticky = w_ctrl_wr & bus.mmio_din[2];

    // A full TX FIFO still accepts a CPU word when the sink drains one this cycle.
    assign w_tx_pop      = ~w_tx_empty & bus.tx_ready;
    assign w_tx_push_req = w_wr & (w_sel == A_TXDATA);
    assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop) & ~w_tx_flush;

    // rx_ready also opens while full if the CPU pops this cycle, so a full RX
    // FIFO can take a stream word in the same cycle as an RXDATA read.
    assign w_rx_pop_req = w_rd & (w_sel == A_RXDATA);
    assign w_rx_pop     = w_rx_pop_req & ~w_rx_empty;
    assign w_rx_ready   = ~w_rx_full | w_rx_pop;
    assign w_rx_push    = bus.rx_valid & w_rx_ready & ~w_rx_flush;

    assign bus.tx_valid  = ~w_tx_empty;
    assign bus.tx_data   = r_tx_mem[r_tx_rd];
    assign bus.rx_ready  = w_rx_ready;
    assign bus.mmio_dout = r_dout;

    always_comb begin
        w_status = '0;
        w_status[0] = w_tx_full;
        w_status[1] = w_tx_empty;
        w_status[2] = w_rx_full;
        w_status[3] = w_rx_empty;
        w_status[4] = r_tx_of;
        w_status[5] = r_rx_uf;
        w_status[8 +: CW]  = r_tx_cnt;
        w_status[16 +: CW] = r_rx_cnt;
    end

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            A_RXDATA: if (!w_rx_empty) w_rd_data = r_rx_mem[r_rx_rd];
            A_STATUS: w_rd_data = w_status;
            default:  w_rd_data = '0;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.mmio_din;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_tx_of  <= 1'b0;
            r_rx_uf  <= 1'b0;
            r_dout   <= '0;
        end else begin
            if (w_tx_flush) begin
                r_tx_wr  <= '0;
                r_tx_rd  <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
                if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
                if (w_tx_push & ~w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
                else if (~w_tx_push & w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
            end

            if (w_rx_flush) begin
                r_rx_wr  <= '0;
                r_rx_rd  <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
                if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
                if (w_rx_push & ~w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
                else if (~w_rx_push & w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
            end

            if (w_clr_sticky) begin
                r_tx_of <= 1'b0;
                r_rx_uf <= 1'b0;
            end else begin
                if (w_tx_push_req & w_tx_full & ~w_tx_pop) r_tx_of <= 1'b1;
                if (w_rx_pop_req & w_rx_empty)             r_rx_uf <= 1'b1;
            end

            if (w_rd) r_dout <= w_rd_data;
        end
    end

`ifdef EXT_STREAM_FIFO_IRQ_EN
    logic [3:0] r_irq_mask;
    logic       r_irq;
    logic [3:0] w_irq_src;

    assign w_irq_src = {r_rx_uf, r_tx_of, ~w_rx_empty, w_tx_empty};
    assign bus.irq   = r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_mask <= bus.mmio_din[7:4];
            r_irq <= |(r_irq_mask & w_irq_src);
        end
    end
`endif
endmodule
